// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves RV32I conditional branches in the execute stage.
// - Compares the forwarded operands according to funct3.
// - Computes pc + imm.
// - Drives a registered one-cycle redirect towards fetch.
// - Runs a flush sequencer that squashes wrong-path instructions in IF/ID.
// - Keeps saturating branch and taken-branch counters for the CSR block.
//
// Parameters
//   FLUSH_CYCLES : cycles `flush` stays high per taken branch (1..15)
//   CNT_W        : width of the performance counters
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   Stall                  : freezes all state and outputs
//   br_valid, funct3       : branch present, branch type
//   rdata_FA_R, rdata_FB_R : forwarded rs1 / rs2 operands
//   pc, imm                : branch PC, sign-extended B-type immediate
//   redirect, target_pc    : registered redirect pulse and target
//   flush                  : squash younger instructions
//   br_illegal             : registered pulse for funct3 010/011
//   br_count, taken_count  : saturating performance counters
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall,
    input  logic             br_valid,
    input  logic [2:0]       funct3,
    input  logic [31:0]      rdata_FA_R,
    input  logic [31:0]      rdata_FB_R,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm,
    output logic             redirect,
    output logic [31:0]      target_pc,
    output logic             flush,
    output logic             br_illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic             redirect_q, redirect_d;
    logic [31:0]      target_q, target_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

    logic cond_taken;
    logic cond_illegal;
    logic accept;
    logic take;

    // ---------------------------------------------------------------- compare
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cond_taken   = 1'b0;
        cond_illegal = 1'b0;
        unique case (funct3)
            3'b000:  cond_taken = (rdata_FA_R == rdata_FB_R);
            3'b001:  cond_taken = (rdata_FA_R != rdata_FB_R);
            3'b100:  cond_taken = ($signed(rdata_FA_R) <  $signed(rdata_FB_R));
            3'b101:  cond_taken = ($signed(rdata_FA_R) >= $signed(rdata_FB_R));
            3'b110:  cond_taken = (rdata_FA_R <  rdata_FB_R);
            3'b111:  cond_taken = (rdata_FA_R >= rdata_FB_R);
            default: cond_illegal = 1'b1;   // 010 / 011: never taken
        endcase
    end

    // Branches arriving while the flush runs are wrong-path and are dropped.
    assign accept = br_valid && !Stall && (state_q == IDLE);
    assign take   = accept && cond_taken;

    // ------------------------------------------------------ FSM: next state
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (!Stall) begin
            unique case (state_q)
                IDLE: begin
                    if (take) begin
                        state_d = FLUSH;
                        fcnt_d  = FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (fcnt_q == 4'd0) state_d = IDLE;
                    else                fcnt_d  = fcnt_q - 4'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------- FSM: output
    always_comb begin
        flush = (state_q == FLUSH);
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        // Pulses hold their level under stall so the consumer still sees them.
        redirect_d = Stall ? redirect_q : take;
        illegal_d  = Stall ? illegal_q  : (accept && cond_illegal);
        target_d   = take ? (pc + imm) : target_q;
        br_cnt_d   = br_cnt_q;
        tk_cnt_d   = tk_cnt_q;
        if (accept && (br_cnt_q != {CNT_W{1'b1}})) br_cnt_d = br_cnt_q + CNT_W'(1);
        if (take   && (tk_cnt_q != {CNT_W{1'b1}})) tk_cnt_d = tk_cnt_q + CNT_W'(1);
    end

    // ------------------------------------------------- FSM + state registers
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fcnt_q     <= 4'd0;
            redirect_q <= 1'b0;
            target_q   <= 32'd0;
            illegal_q  <= 1'b0;
            br_cnt_q   <= '0;
            tk_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            illegal_q  <= illegal_d;
            br_cnt_q   <= br_cnt_d;
            tk_cnt_q   <= tk_cnt_d;
        end
    end

    assign redirect    = redirect_q;
    assign target_pc   = target_q;
    assign br_illegal  = illegal_q;
    assign br_count    = br_cnt_q;
    assign taken_count = tk_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// Directed bench for branch_resolve_unit.
// dut  : FLUSH_CYCLES=2, CNT_W=16 (main function, stall, reset, illegal)
// dut4 : FLUSH_CYCLES=1, CNT_W=4  (counter saturation)
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst, stall, br_valid;
    logic [2:0]  funct3;
    logic [31:0] fa, fb, pc, imm;
    logic        redirect, flush, br_illegal;
    logic [31:0] target_pc;
    logic [15:0] br_count, taken_count;

    logic        rst4, br_valid4;
    logic        redirect4, flush4, br_illegal4;
    logic [31:0] target_pc4;
    logic [3:0]  br_count4, taken_count4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .Stall(stall), .br_valid(br_valid),
        .funct3(funct3), .rdata_FA_R(fa), .rdata_FB_R(fb), .pc(pc), .imm(imm),
        .redirect(redirect), .target_pc(target_pc), .flush(flush),
        .br_illegal(br_illegal), .br_count(br_count), .taken_count(taken_count)
    );

    branch_resolve_unit #(.FLUSH_CYCLES(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .Stall(1'b0), .br_valid(br_valid4),
        .funct3(funct3), .rdata_FA_R(fa), .rdata_FB_R(fb), .pc(pc), .imm(imm),
        .redirect(redirect4), .target_pc(target_pc4), .flush(flush4),
        .br_illegal(br_illegal4), .br_count(br_count4), .taken_count(taken_count4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic [31:0] i);
        funct3 = f3; fa = a; fb = b; pc = p; imm = i;
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1; stall = 1'b0; br_valid = 1'b0; br_valid4 = 1'b0;
        set_br(3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0; rst4 = 1'b0;

        // Reset state
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_target",   target_pc,     32'd0);
        check("rst_flush",    32'(flush),    32'd0);
        check("rst_illegal",  32'(br_illegal), 32'd0);
        check("rst_brcnt",    32'(br_count), 32'd0);
        check("rst_tkcnt",    32'(taken_count), 32'd0);

        // BEQ taken; br_valid stays high across the flush -> ignored
        set_br(3'b000, 32'h5, 32'h5, 32'h100, 32'h20);
        br_valid = 1'b1;
        tick();
        check("beq_redirect", 32'(redirect), 32'd1);
        check("beq_target",   target_pc,     32'h120);
        check("beq_flush",    32'(flush),    32'd1);
        check("beq_brcnt",    32'(br_count), 32'd1);
        check("beq_tkcnt",    32'(taken_count), 32'd1);
        tick();
        check("beq_f2_redirect", 32'(redirect), 32'd0);
        check("beq_f2_flush",    32'(flush),    32'd1);
        check("beq_f2_brcnt",    32'(br_count), 32'd1);
        tick();  // FLUSH exits on this edge; branch presented here is ignored
        check("beq_exit_flush",    32'(flush),    32'd0);
        check("beq_exit_redirect", 32'(redirect), 32'd0);
        check("beq_exit_brcnt",    32'(br_count), 32'd1);
        br_valid = 1'b0;

        // BLT signed: -1 < 1 -> taken, negative immediate
        set_br(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFF0);
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("blt_redirect", 32'(redirect), 32'd1);
        check("blt_target",   target_pc,     32'h1F0);
        check("blt_tkcnt",    32'(taken_count), 32'd2);
        tick();
        tick();
        check("blt_flush_done", 32'(flush), 32'd0);

        // BLTU unsigned: 0xFFFFFFFF < 1 false -> not taken
        set_br(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h600, 32'h40);
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("bltu_redirect", 32'(redirect), 32'd0);
        check("bltu_target",   target_pc,     32'h1F0);
        check("bltu_flush",    32'(flush),    32'd0);
        check("bltu_brcnt",    32'(br_count), 32'd3);
        check("bltu_tkcnt",    32'(taken_count), 32'd2);

        // BNE taken, then 3 stalled cycles inside FLUSH
        set_br(3'b001, 32'h1, 32'h2, 32'h300, 32'h8);
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("bne_redirect", 32'(redirect), 32'd1);
        check("bne_target",   target_pc,     32'h308);
        stall = 1'b1;
        br_valid = 1'b1;  // must not be accepted while stalled
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_redirect", 32'(redirect), 32'd1);
            check("stall_flush",    32'(flush),    32'd1);
            check("stall_brcnt",    32'(br_count), 32'd4);
            check("stall_tkcnt",    32'(taken_count), 32'd3);
        end
        stall = 1'b0;
        br_valid = 1'b0;
        tick();
        check("bne_post_redirect", 32'(redirect), 32'd0);
        check("bne_post_flush",    32'(flush),    32'd1);
        tick();
        check("bne_flush_done",    32'(flush),    32'd0);

        // Illegal funct3
        set_br(3'b010, 32'h7, 32'h7, 32'h700, 32'h10);
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("ill_pulse",    32'(br_illegal), 32'd1);
        check("ill_redirect", 32'(redirect),   32'd0);
        check("ill_flush",    32'(flush),      32'd0);
        check("ill_brcnt",    32'(br_count),   32'd5);
        check("ill_tkcnt",    32'(taken_count), 32'd3);
        tick();
        check("ill_clear",    32'(br_illegal), 32'd0);

        // BGE signed: -1 >= 1 false; BGEU: 0xFFFFFFFF >= 1 true
        set_br(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h800, 32'h4);
        br_valid = 1'b1;
        tick();
        check("bge_redirect", 32'(redirect), 32'd0);
        set_br(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h400, 32'h4);
        tick();
        br_valid = 1'b0;
        check("bgeu_redirect", 32'(redirect), 32'd1);
        check("bgeu_target",   target_pc,     32'h404);
        check("bgeu_brcnt",    32'(br_count), 32'd7);
        check("bgeu_tkcnt",    32'(taken_count), 32'd4);
        tick();
        tick();

        // Reset during FLUSH with Stall high
        set_br(3'b000, 32'h9, 32'h9, 32'h0, 32'h10);
        br_valid = 1'b1;
        tick();
        br_valid = 1'b0;
        check("pre_rst_redirect", 32'(redirect), 32'd1);
        stall = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall = 1'b0;
        check("mid_rst_redirect", 32'(redirect), 32'd0);
        check("mid_rst_flush",    32'(flush),    32'd0);
        check("mid_rst_target",   target_pc,     32'd0);
        check("mid_rst_brcnt",    32'(br_count), 32'd0);
        check("mid_rst_tkcnt",    32'(taken_count), 32'd0);
        tick();
        check("post_rst_flush",   32'(flush),    32'd0);

        // Saturation on dut4 (FLUSH_CYCLES=1: one accept every two cycles)
        set_br(3'b000, 32'h3, 32'h3, 32'h1000, 32'h4);
        br_valid4 = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_mid_tkcnt", 32'(taken_count4), 32'd10);
        check("sat_mid_flush", 32'(flush4),       32'd0);
        for (int i = 0; i < 20; i++) tick();
        br_valid4 = 1'b0;
        check("sat_tkcnt", 32'(taken_count4), 32'd15);
        check("sat_brcnt", 32'(br_count4),    32'd15);
        check("sat_main_idle_brcnt", 32'(br_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
